trapezoid_raster_gen2: RTL and testbench

Parametrised scan-line trapezoid rasteriser, successor to the fixed 8-bit trapezoid renderer. It receives four vertices of a trapezoid with horizontal top and bottom edges and computes edge slopes with an on-chip sequential divider. It streams covered pixel coordinates bottom-to-top, left-to-right, under a valid/ready output handshake. A mode input selects filled or outline rendering.

---
 rtl/trapezoid_raster_gen2.sv | 230 +++++++++++++++++++++++
 tb/tb_trapezoid_raster_gen2.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trapezoid_raster_gen2.sv
// Scan-line trapezoid rasteriser: captures four vertices, derives both edge slopes
// with two parallel restoring dividers, then streams covered pixels bottom-to-top.
module trapezoid_raster_gen2 #(
    parameter int CW = 8,
    parameter int FW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          nt,
    input  logic [CW-1:0] xi,
    input  logic [CW-1:0] yi,
    input  logic          mode,
    output logic          busy,
    output logic          po,
    input  logic          ordy,
    output logic [CW-1:0] xo,
    output logic [CW-1:0] yo,
    output logic          done,
    output logic          err
);
    localparam int AW  = CW + FW;
    localparam int CW1 = CW + 1;
    localparam int DCW = $clog2(AW);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_CHECK    = 3'd2;
    localparam logic [2:0] S_DIV      = 3'd3;
    localparam logic [2:0] S_ROW_INIT = 3'd4;
    localparam logic [2:0] S_EMIT     = 3'd5;
    localparam logic [2:0] S_ROW_STEP = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]           r_state;
    logic [1:0]           r_load_cnt;
    logic                 r_mode;
    logic [CW-1:0]        r_xl_top, r_xr_top, r_xl_bot, r_xr_bot;
    logic [CW-1:0]        r_y_top, r_y_bot;
    logic [CW-1:0]        r_dy;
    logic [DCW-1:0]       r_div_cnt;
    logic [1:0][CW-1:0]   r_rem;
    logic [1:0][AW-1:0]   r_quo;
    logic [1:0]           r_neg;
    logic [AW-1:0]        r_xl, r_xr;
    logic [CW-1:0]        r_y;
    logic [CW:0]          r_col, r_xe;
    logic                 r_po;
    logic [CW-1:0]        r_xo, r_yo;
    logic                 r_err;

    // Edge deltas (top - bottom) split into sign and magnitude for the dividers.
    logic [CW:0]          w_dx_l, w_dx_r;
    logic [CW-1:0]        w_mag_l, w_mag_r;

    assign w_dx_l  = {1'b0, r_xl_top} - {1'b0, r_xl_bot};
    assign w_dx_r  = {1'b0, r_xr_top} - {1'b0, r_xr_bot};
    assign w_mag_l = w_dx_l[CW] ? (~w_dx_l[CW-1:0] + CW'(1)) : w_dx_l[CW-1:0];
    assign w_mag_r = w_dx_r[CW] ? (~w_dx_r[CW-1:0] + CW'(1)) : w_dx_r[CW-1:0];

    logic [1:0][CW:0]     w_trial;
    logic [1:0]           w_fit;
    logic [1:0][CW-1:0]   w_rem_next;
    logic [1:0][AW-1:0]   w_slope;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_trial[i]    = {r_rem[i], r_quo[i][AW-1]};
            w_fit[i]      = (w_trial[i] >= {1'b0, r_dy});
            w_rem_next[i] = w_fit[i] ? (w_trial[i][CW-1:0] - r_dy) : w_trial[i][CW-1:0];
            // Low AW bits of the signed slope suffice: the accumulators add modulo 2^AW.
            w_slope[i]    = r_neg[i] ? (AW'(0) - r_quo[i]) : r_quo[i];
        end
    end

    // Row under evaluation: the current one in ROW_INIT, the next one in ROW_STEP.
    logic                 w_step;
    logic [CW-1:0]        w_row_y;
    logic [AW-1:0]        w_row_xl, w_row_xr;
    logic                 w_top_row;
    logic [AW-1:0]        w_span_xl, w_span_xr;
    logic [CW:0]          w_xs, w_xe;
    logic                 w_row_empty;

    assign w_step      = (r_state == S_ROW_STEP);
    assign w_row_y     = w_step ? (r_y + CW'(1)) : r_y;
    assign w_row_xl    = w_step ? (r_xl + w_slope[0]) : r_xl;
    assign w_row_xr    = w_step ? (r_xr + w_slope[1]) : r_xr;
    assign w_top_row   = (w_row_y == r_y_top);
    assign w_span_xl   = w_top_row ? {r_xl_top, {FW{1'b0}}} : w_row_xl;
    assign w_span_xr   = w_top_row ? {r_xr_top, {FW{1'b0}}} : w_row_xr;
    assign w_xs        = {1'b0, w_span_xl[AW-1:FW]} + CW1'(|w_span_xl[FW-1:0]);
    assign w_xe        = {1'b0, w_span_xr[AW-1:FW]};
    assign w_row_empty = (w_xs > w_xe);

    // Outline middle rows jump from xs straight to xe; the extra counter bit stops x=max wrapping.
    logic                 w_full_row;
    logic [CW:0]          w_next_col;
    logic                 w_row_end;

    assign w_full_row = !r_mode || (r_y == r_y_bot) || (r_y == r_y_top);
    assign w_next_col = (!w_full_row && (r_col < r_xe)) ? r_xe : (r_col + CW1'(1));
    assign w_row_end  = (w_next_col > r_xe);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_load_cnt <= '0;
            r_mode     <= 1'b0;
            r_xl_top   <= '0;
            r_xr_top   <= '0;
            r_xl_bot   <= '0;
            r_xr_bot   <= '0;
            r_y_top    <= '0;
            r_y_bot    <= '0;
            r_dy       <= '0;
            r_div_cnt  <= '0;
            // NOTE: the divider lanes are plain registers, so they are cleared with everything else.
            r_rem      <= '0;
            r_quo      <= '0;
            r_neg      <= '0;
            r_xl       <= '0;
            r_xr       <= '0;
            r_y        <= '0;
            r_col      <= '0;
            r_xe       <= '0;
            r_po       <= 1'b0;
            r_xo       <= '0;
            r_yo       <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (nt) begin
                        r_xl_top   <= xi;
                        r_y_top    <= yi;
                        r_mode     <= mode;
                        r_err      <= 1'b0;
                        r_load_cnt <= '0;
                        r_state    <= S_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    case (r_load_cnt)
                        2'd0:    r_xr_top <= xi;
                        2'd1: begin
                            r_xl_bot <= xi;
                            r_y_bot  <= yi;
                        end
                        default: r_xr_bot <= xi;
                    endcase
                    r_load_cnt <= r_load_cnt + 2'd1;
                    if (r_load_cnt == 2'd2) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_xl      <= {r_xl_bot, {FW{1'b0}}};
                    r_xr      <= {r_xr_bot, {FW{1'b0}}};
                    r_y       <= r_y_bot;
                    r_dy      <= r_y_top - r_y_bot;
                    r_div_cnt <= '0;
                    r_rem     <= '0;
                    r_neg     <= {w_dx_r[CW], w_dx_l[CW]};
                    if (r_y_top < r_y_bot) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_y_top == r_y_bot) begin
                        r_quo   <= '0;
                        r_state <= S_ROW_INIT;
                    end else begin
                        r_quo[0] <= {w_mag_l, {FW{1'b0}}};
                        r_quo[1] <= {w_mag_r, {FW{1'b0}}};
                        r_state  <= S_DIV;
                    end
                end
                S_DIV: begin
                    for (int i = 0; i < 2; i++) begin
                        r_rem[i] <= w_rem_next[i];
                        r_quo[i] <= {r_quo[i][AW-2:0], w_fit[i]};
                    end
                    r_div_cnt <= r_div_cnt + DCW'(1);
                    if (r_div_cnt == DCW'(AW - 1)) begin
                        r_state <= S_ROW_INIT;
                    end
                end
                S_ROW_INIT, S_ROW_STEP: begin
                    r_xl  <= w_row_xl;
                    r_xr  <= w_row_xr;
                    r_y   <= w_row_y;
                    r_col <= w_xs;
                    r_xe  <= w_xe;
                    if (!w_row_empty) begin
                        r_po    <= 1'b1;
                        r_xo    <= w_xs[CW-1:0];
                        r_yo    <= w_row_y;
                        r_state <= S_EMIT;
                    end else if (w_top_row) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_ROW_STEP;
                    end
                end
                S_EMIT: begin
                    if (ordy) begin
                        if (w_row_end) begin
                            r_po    <= 1'b0;
                            r_state <= (r_y == r_y_top) ? S_DONE : S_ROW_STEP;
                        end else begin
                            r_col <= w_next_col;
                            r_xo  <= w_next_col[CW-1:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done = (r_state == S_DONE);
    assign po   = r_po;
    assign xo   = r_xo;
    assign yo   = r_yo;
    assign err  = r_err;

endmodule

// File: tb/tb_trapezoid_raster_gen2.sv
// Scoreboard bench for trapezoid_raster_gen2: directed trapezoids queue their expected
// pixels, and an independent monitor pops and compares each handshake transfer.
module tb_trapezoid_raster_gen2;
    localparam int CW = 8;
    localparam int FW = 16;

    logic          clk;
    logic          reset;
    logic          nt;
    logic [CW-1:0] xi;
    logic [CW-1:0] yi;
    logic          mode;
    logic          busy;
    logic          po;
    logic          ordy;
    logic [CW-1:0] xo;
    logic [CW-1:0] yo;
    logic          done;
    logic          err;

    trapezoid_raster_gen2 #(.CW(CW), .FW(FW)) dut (
        .clk   (clk),
        .reset (reset),
        .nt    (nt),
        .xi    (xi),
        .yi    (yi),
        .mode  (mode),
        .busy  (busy),
        .po    (po),
        .ordy  (ordy),
        .xo    (xo),
        .yo    (yo),
        .done  (done),
        .err   (err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          v3_cyc   = 0;
    int          first_po_cyc = -1;
    int          last_xfer_cyc = -1;
    int          n_xfer   = 0;
    bit          bp_en    = 0;
    logic [15:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        ordy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ordy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: one comparison per transfer, plus hold checks while stalled.
    initial begin
        bit          prev_stall;
        logic [15:0] prev_xy;
        logic [15:0] exp_xy;
        prev_stall = 0;
        prev_xy    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (prev_stall) begin
                    check("hold_po", 32'(po), 32'd1);
                    check("hold_xy", 32'({xo, yo}), 32'(prev_xy));
                end
                if (po && first_po_cyc < 0) first_po_cyc = cyc;
                if (po && ordy) begin
                    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        exp_xy = sb.pop_front();
                        check("pixel_xy", 32'({xo, yo}), 32'(exp_xy));
                    end
                    n_xfer++;
                    last_xfer_cyc = cyc;
                end
                prev_stall = po && !ordy;
                prev_xy    = {xo, yo};
            end else begin
                prev_stall = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input int y, input int xs, input int xe);
        for (int x = xs; x <= xe; x++) sb.push_back({8'(x), 8'(y)});
    endtask

    task automatic push_px(input int x, input int y);
        sb.push_back({8'(x), 8'(y)});
    endtask

    task automatic send_trap(input string tag, input int x0, input int y0, input int x1,
                             input int x2, input int y2, input int x3, input logic md);
        first_po_cyc  = -1;
        last_xfer_cyc = -1;
        n_xfer        = 0;
        nt = 1'b1; xi = 8'(x0); yi = 8'(y0); mode = md;
        tick();
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        check({tag, "_err_clear"}, 32'(err), 32'd0);
        nt = 1'b0; xi = 8'(x1); yi = 8'hA5; mode = ~md;
        tick();
        xi = 8'(x2); yi = 8'(y2);
        tick();
        xi = 8'(x3); yi = 8'h3C;
        tick();
        v3_cyc = cyc;
        xi = '0; yi = '0;
    endtask

    task automatic wait_done(input string tag, input int lat, input int npx,
                             input logic exp_err, input bit pulse_nt);
        bit got_done;
        int done_cyc;
        got_done = 0;
        done_cyc = -1;
        for (int i = 0; i < 3000 && !got_done; i++) begin
            @(negedge clk);
            nt = 1'b0;
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
                check({tag, "_busy_fall"}, 32'(busy), 32'd0);
                check({tag, "_err"}, 32'(err), 32'(exp_err));
            end else begin
                nt = pulse_nt && busy && (i % 7 == 3);
                xi = 8'(i);
                yi = 8'(i + 1);
            end
        end
        nt = 1'b0;
        check({tag, "_done_seen"}, 32'(got_done), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_err_hold"}, 32'(err), 32'(exp_err));
        check({tag, "_count"}, 32'(n_xfer), 32'(npx));
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        if (npx > 0) check({tag, "_done_after_last"}, 32'(done_cyc), 32'(last_xfer_cyc + 1));
        else         check({tag, "_no_po"}, 32'(first_po_cyc), 32'hFFFF_FFFF);
        if (lat >= 0) check({tag, "_latency"}, 32'(first_po_cyc - v3_cyc), 32'(lat));
        sb.delete();
        repeat (3) tick();
    endtask

    task automatic push_fill_case();
        push_row(1, 0, 8);
        push_row(2, 1, 7);
        push_row(3, 1, 7);
        push_row(4, 2, 6);
        push_row(5, 2, 6);
    endtask

    initial begin
        bit got;
        reset = 1'b0; nt = 1'b0; xi = '0; yi = '0; mode = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_po",   32'(po),   32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_xy",   32'({xo, yo}), 32'd0);
        tick();
        reset = 1'b1;
        repeat (2) tick();

        // Fill: left edge 0->2, right edge 8->6 over rows 1..5.
        push_fill_case();
        send_trap("fill", 2, 5, 6, 0, 1, 8, 1'b0);
        wait_done("fill", 26, 33, 1'b0, 0);

        // Outline: full first/last rows, endpoints only on rows 2..4.
        push_row(1, 0, 8);
        push_px(1, 2); push_px(7, 2);
        push_px(1, 3); push_px(7, 3);
        push_px(2, 4); push_px(6, 4);
        push_row(5, 2, 6);
        send_trap("outline", 2, 5, 6, 0, 1, 8, 1'b1);
        wait_done("outline", 26, 20, 1'b0, 0);

        // Single row: divider skipped.
        push_row(3, 4, 6);
        send_trap("single", 4, 3, 6, 4, 3, 6, 1'b0);
        wait_done("single", 2, 3, 1'b0, 0);

        // Empty bottom row (xs=4 > xe=3), then one pixel on the top row.
        push_px(4, 1);
        send_trap("empty", 4, 1, 4, 4, 0, 3, 1'b0);
        wait_done("empty", 27, 1, 1'b0, 0);

        // Span ending at the largest coordinate must stop without wrapping to 0.
        push_row(7, 253, 255);
        send_trap("xmax", 253, 7, 255, 253, 7, 255, 1'b1);
        wait_done("xmax", 2, 3, 1'b0, 0);

        // Backpressure with stray nt pulses while busy.
        bp_en = 1;
        push_fill_case();
        send_trap("bp", 2, 5, 6, 0, 1, 8, 1'b0);
        wait_done("bp", -1, 33, 1'b0, 1);
        bp_en = 0;
        repeat (2) tick();

        // Inverted geometry: rejected with err and no pixels.
        send_trap("geom_err", 3, 2, 7, 3, 5, 7, 1'b0);
        wait_done("geom_err", -1, 0, 1'b1, 0);

        // Asynchronous reset in the middle of EMIT.
        push_fill_case();
        send_trap("abort", 2, 5, 6, 0, 1, 8, 1'b0);
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = (n_xfer >= 5);
        end
        check("abort_reached_emit", 32'(got), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_po",   32'(po),   32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_xy",   32'({xo, yo}), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        sb.delete();
        tick();
        reset = 1'b1;
        repeat (2) tick();

        push_row(3, 4, 6);
        send_trap("post_rst", 4, 3, 6, 4, 3, 6, 1'b0);
        wait_done("post_rst", 2, 3, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
